avlnst_frame_checker: RTL and testbench
=======================================

AVLNST_FRAME_CHECKER -- requirements
Module: avlnst_frame_checker

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 1, stream data width.
REQ-002 SHALL have parameter MAX_LEN, default 1024, maximum legal frame length in beats (>=2).
REQ-003 SHALL have parameter CNT_WIDTH, default 16, statistics counter width.
REQ-004 SHALL have ports:
  i_clk  in  1  clock
  i_rst_n  in  1  reset, asynchronous, active-low
  i_data  in  DATA_WIDTH  stream data
  i_vld  in  1  beat valid
  i_sof  in  1  start of frame, qualified by i_vld
  i_eof  in  1  end of frame, qualified by i_vld
  i_clr_cnt  in  1  synchronous clear of statistics counters
  o_data  out  DATA_WIDTH  cleaned stream data
  o_vld  out  1  cleaned beat valid
  o_sof  out  1  cleaned start of frame
  o_eof  out  1  cleaned end of frame
  o_err_orphan  out  1  pulse: beat outside a frame dropped
  o_err_nested  out  1  pulse: sof inside an open frame
  o_err_overlen  out  1  pulse: frame truncated at MAX_LEN
  o_frame_cnt  out  CNT_WIDTH  frames closed
  o_err_cnt  out  CNT_WIDTH  error events
REQ-005 SHALL have no ready/backpressure; every accepted beat is processed in its arrival cycle.

Function
REQ-006 SHALL register all outputs; latency from input beat to output beat/error pulse is exactly 1 cycle.
REQ-007 SHALL implement FSM states IDLE, IN_FRAME, DISCARD; beat counter width $clog2(MAX_LEN+1), sof beat counts as 1.
REQ-008 IDLE: i_vld&i_sof&i_eof -> emit single-beat frame (sof=eof=1), stay IDLE; i_vld&i_sof&!i_eof -> emit, count=1, go IN_FRAME.
REQ-009 IDLE: i_vld&!i_sof (eof or not) -> drop beat, o_err_orphan pulse, stay IDLE.
REQ-010 IN_FRAME: i_vld&!i_sof -> emit, count+1; if i_eof -> go IDLE.
REQ-011 IN_FRAME: beat making count==MAX_LEN without i_eof -> emit with o_eof forced 1, o_err_overlen pulse, go DISCARD.
REQ-012 IN_FRAME: i_vld&i_sof -> emit as new frame start (o_sof=1), o_err_nested pulse, count=1; with i_eof go IDLE, else stay IN_FRAME.
REQ-013 DISCARD: beats without sof dropped silently; i_eof without sof -> go IDLE; i_sof handled exactly as in IDLE (REQ-008).
REQ-014 Cycles with i_vld=0 SHALL produce o_vld=o_sof=o_eof=0, no error pulse, no state change; o_data holds last value.
REQ-015 o_sof/o_eof SHALL be 0 whenever o_vld=0; at most one error pulse per cycle.
REQ-016 o_frame_cnt SHALL increment on each emitted beat with o_eof=1 (including forced); saturates at all-ones.
REQ-017 o_err_cnt SHALL increment on each cycle with any error pulse; saturates at all-ones.
REQ-018 i_clr_cnt SHALL zero both counters next cycle, taking priority over a same-cycle increment.

Reset
REQ-019 Reset SHALL force state IDLE, beat count 0, all outputs 0 including o_data and counters.
REQ-020 Reset mid-frame SHALL abandon the frame without emitting eof; first post-reset beat is evaluated as in IDLE.

Configuration
REQ-021 With macro AVLNST_FRAME_CHECKER_STATS_EN defined, o_frame_cnt/o_err_cnt and i_clr_cnt SHALL behave per REQ-016..018.
REQ-022 Without it, counters SHALL not be built, o_frame_cnt/o_err_cnt SHALL be tied 0, i_clr_cnt ignored; error pulses unchanged.

Structure
REQ-023 Package avlnst_pkg SHALL hold the FSM state typedef (IDLE, IN_FRAME, DISCARD); counters and widths stay local.
REQ-024 No sub-module; output register stage is in-block (output may feed hyper_avlnST for retiming).

Verification (MAX_LEN=4, CNT_WIDTH=16, stats enabled)
REQ-025 Frame sof,d,d,eof (data 1..4) -> same 4 beats out 1 cycle later, o_frame_cnt=1, no errors.
REQ-026 Beat data 7 with sof=eof=0 in IDLE -> o_vld=0, o_err_orphan=1 one cycle, o_err_cnt=1.
REQ-027 Six beats, sof on first, no eof -> beats 1..4 out, beat 4 o_eof=1, o_err_overlen=1, beats 5..6 dropped, o_frame_cnt=1.
REQ-028 sof,d,sof,eof -> 4 beats out, o_sof on beats 1 and 3, o_err_nested on beat 3, o_frame_cnt=1, o_err_cnt=1.
REQ-029 Reset asserted after sof,d; release, send d,eof -> both dropped with two o_err_orphan pulses, all outputs 0 during reset.
REQ-030 i_clr_cnt coincident with an eof beat -> counters read 0 next cycle.

Source files
------------

// File: rtl/avlnst_pkg.sv
// Shared types for the Avalon-ST frame checker: the frame FSM state encoding.
// Counter widths and beat widths are local to the checker itself.
package avlnst_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    IN_FRAME = 2'd1,
    DISCARD  = 2'd2
  } state_e;

endpackage : avlnst_pkg

// File: rtl/avlnst_frame_checker.sv
// Avalon-ST frame checker / cleaner.
// Watches a valid-qualified sof/eof stream with no backpressure, repairs the
// framing and flags the problems it sees:
//   - beats outside a frame are dropped (o_err_orphan)
//   - a sof inside an open frame starts a new frame (o_err_nested)
//   - a frame reaching MAX_LEN beats without eof is closed with a forced eof,
//     and the rest of it is discarded up to its eof (o_err_overlen)
// Every output is registered, so each beat and error pulse appears exactly
// one cycle after its input beat.
// Optional feature: define AVLNST_FRAME_CHECKER_STATS_EN to build saturating
// frame / error counters with a synchronous clear. Without it the counters
// read 0 and i_clr_cnt is ignored.
module avlnst_frame_checker
  import avlnst_pkg::*;
#(
  parameter int DATA_WIDTH = 1,
  parameter int MAX_LEN    = 1024,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_vld,
  input  logic                  i_sof,
  input  logic                  i_eof,
  input  logic                  i_clr_cnt,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_vld,
  output logic                  o_sof,
  output logic                  o_eof,
  output logic                  o_err_orphan,
  output logic                  o_err_nested,
  output logic                  o_err_overlen,
  output logic [CNT_WIDTH-1:0]  o_frame_cnt,
  output logic [CNT_WIDTH-1:0]  o_err_cnt
);

  localparam int                BEAT_W    = $clog2(MAX_LEN + 1);
  localparam logic [BEAT_W-1:0] MAX_BEATS = BEAT_W'(MAX_LEN);

  state_e                  state_q, state_d;
  logic [BEAT_W-1:0]       beat_cnt_q, beat_cnt_d;
  logic [BEAT_W-1:0]       beat_inc;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    vld_q, vld_d;
  logic                    sof_q, sof_d;
  logic                    eof_q, eof_d;
  logic                    orphan_q, orphan_d;
  logic                    nested_q, nested_d;
  logic                    overlen_q, overlen_d;

  assign beat_inc = beat_cnt_q + 1'b1;

  // Next-state and next-output decision for the beat arriving this cycle.
  always_comb begin
    // NOTE: every signal written here gets a default first so that no path
    // leaves it unassigned; otherwise synthesis infers a latch.
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    data_d     = data_q;
    vld_d      = 1'b0;
    sof_d      = 1'b0;
    eof_d      = 1'b0;
    orphan_d   = 1'b0;
    nested_d   = 1'b0;
    overlen_d  = 1'b0;

    if (i_vld) begin
      unique case (state_q)
        IDLE, DISCARD: begin
          if (i_sof) begin
            // A sof opens a frame whether we were idle or discarding.
            vld_d  = 1'b1;
            sof_d  = 1'b1;
            data_d = i_data;
            if (i_eof) begin
              eof_d      = 1'b1;
              state_d    = IDLE;
              beat_cnt_d = '0;
            end else begin
              state_d    = IN_FRAME;
              beat_cnt_d = BEAT_W'(1);
            end
          end else if (state_q == IDLE) begin
            orphan_d = 1'b1;
          end else if (i_eof) begin
            // End of the truncated tail: dropped silently, back to idle.
            state_d = IDLE;
          end
        end

        IN_FRAME: begin
          vld_d  = 1'b1;
          data_d = i_data;
          if (i_sof) begin
            // Restart: the unterminated frame is abandoned, this beat leads.
            sof_d    = 1'b1;
            nested_d = 1'b1;
            if (i_eof) begin
              eof_d      = 1'b1;
              state_d    = IDLE;
              beat_cnt_d = '0;
            end else begin
              beat_cnt_d = BEAT_W'(1);
            end
          end else if (i_eof) begin
            eof_d      = 1'b1;
            state_d    = IDLE;
            beat_cnt_d = '0;
          end else if (beat_inc == MAX_BEATS) begin
            eof_d      = 1'b1;
            overlen_d  = 1'b1;
            state_d    = DISCARD;
            beat_cnt_d = '0;
          end else begin
            beat_cnt_d = beat_inc;
          end
        end

        default: begin
          state_d    = IDLE;
          beat_cnt_d = '0;
        end
      endcase
    end
  end

  // State, beat count and the registered output stage.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    // NOTE: every flop here, o_data included, is reset so the outputs are
    // fully defined (all zero) while reset is held.
    if (!i_rst_n) begin
      state_q    <= IDLE;
      beat_cnt_q <= '0;
      data_q     <= '0;
      vld_q      <= 1'b0;
      sof_q      <= 1'b0;
      eof_q      <= 1'b0;
      orphan_q   <= 1'b0;
      nested_q   <= 1'b0;
      overlen_q  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops
      // sample their _d values from the same pre-edge snapshot.
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      data_q     <= data_d;
      vld_q      <= vld_d;
      sof_q      <= sof_d;
      eof_q      <= eof_d;
      orphan_q   <= orphan_d;
      nested_q   <= nested_d;
      overlen_q  <= overlen_d;
    end
  end

  assign o_data        = data_q;
  assign o_vld         = vld_q;
  assign o_sof         = sof_q;
  assign o_eof         = eof_q;
  assign o_err_orphan  = orphan_q;
  assign o_err_nested  = nested_q;
  assign o_err_overlen = overlen_q;

`ifdef AVLNST_FRAME_CHECKER_STATS_EN
  logic [CNT_WIDTH-1:0] frame_cnt_q, frame_cnt_d;
  logic [CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
  logic                 err_event;

  // The three error sources are mutually exclusive; any of them is one event.
  assign err_event = orphan_d | nested_d | overlen_d;

  // Saturating counters; clear wins over a same-cycle increment. They count
  // off the _d values so they step in the same cycle as the pulse appears.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    err_cnt_d   = err_cnt_q;
    if (i_clr_cnt) begin
      frame_cnt_d = '0;
      err_cnt_d   = '0;
    end else begin
      if (eof_d && (frame_cnt_q != '1)) frame_cnt_d = frame_cnt_q + 1'b1;
      if (err_event && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  // Statistics counter registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign o_frame_cnt = frame_cnt_q;
  assign o_err_cnt   = err_cnt_q;
`else
  logic unused_clr_cnt;

  assign unused_clr_cnt = i_clr_cnt;
  assign o_frame_cnt    = '0;
  assign o_err_cnt      = '0;
`endif

endmodule : avlnst_frame_checker

// File: tb/tb_avlnst_frame_checker.sv
// Directed bench for avlnst_frame_checker with MAX_LEN=4, 8-bit data.
// Inputs change #1 after the rising edge; outputs are sampled #1 after the
// edge that registers the beat. Counter expectations follow the build: with
// AVLNST_FRAME_CHECKER_STATS_EN they track the stream, otherwise they are 0.
module tb_avlnst_frame_checker;

  localparam int DW = 8;
  localparam int CW = 16;
`ifdef AVLNST_FRAME_CHECKER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          i_clk = 1'b0;
  logic          i_rst_n;
  logic [DW-1:0] i_data;
  logic          i_vld, i_sof, i_eof, i_clr_cnt;
  logic [DW-1:0] o_data;
  logic          o_vld, o_sof, o_eof;
  logic          o_err_orphan, o_err_nested, o_err_overlen;
  logic [CW-1:0] o_frame_cnt, o_err_cnt;

  int checks = 0;
  int errors = 0;

  avlnst_frame_checker #(
    .DATA_WIDTH (DW),
    .MAX_LEN    (4),
    .CNT_WIDTH  (CW)
  ) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_data        (i_data),
    .i_vld         (i_vld),
    .i_sof         (i_sof),
    .i_eof         (i_eof),
    .i_clr_cnt     (i_clr_cnt),
    .o_data        (o_data),
    .o_vld         (o_vld),
    .o_sof         (o_sof),
    .o_eof         (o_eof),
    .o_err_orphan  (o_err_orphan),
    .o_err_nested  (o_err_nested),
    .o_err_overlen (o_err_overlen),
    .o_frame_cnt   (o_frame_cnt),
    .o_err_cnt     (o_err_cnt)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [31:0] cexp(input int n);
    return STATS ? 32'(n) : 32'd0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one input cycle and move to the sample point after the next edge.
  task automatic step(input logic vld, input logic sof, input logic eof,
                      input logic [DW-1:0] data, input logic clr);
    i_vld     = vld;
    i_sof     = sof;
    i_eof     = eof;
    i_data    = data;
    i_clr_cnt = clr;
    @(posedge i_clk);
    #1;
  endtask

  // Compare every output; o_data is only meaningful on a valid beat.
  task automatic expect_out(input string tag, input logic vld, input logic sof,
                            input logic eof, input logic [DW-1:0] data,
                            input logic orph, input logic nest, input logic over,
                            input int fcnt, input int ecnt);
    check({tag, ".vld"},     32'(o_vld),         32'(vld));
    check({tag, ".sof"},     32'(o_sof),         32'(sof));
    check({tag, ".eof"},     32'(o_eof),         32'(eof));
    if (vld) check({tag, ".data"}, 32'(o_data), 32'(data));
    check({tag, ".orphan"},  32'(o_err_orphan),  32'(orph));
    check({tag, ".nested"},  32'(o_err_nested),  32'(nest));
    check({tag, ".overlen"}, 32'(o_err_overlen), 32'(over));
    check({tag, ".fcnt"},    32'(o_frame_cnt),   cexp(fcnt));
    check({tag, ".ecnt"},    32'(o_err_cnt),     cexp(ecnt));
  endtask

  task automatic expect_all_zero(input string tag);
    check({tag, ".data"}, 32'(o_data), 32'd0);
    expect_out(tag, 0, 0, 0, 8'd0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    i_rst_n   = 1'b0;
    i_vld     = 1'b0;
    i_sof     = 1'b0;
    i_eof     = 1'b0;
    i_data    = '0;
    i_clr_cnt = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    expect_all_zero("reset");
    i_rst_n = 1'b1;

    // Clean 4-beat frame.
    step(1, 1, 0, 8'd1, 0); expect_out("f1.b1", 1, 1, 0, 8'd1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 8'd2, 0); expect_out("f1.b2", 1, 0, 0, 8'd2, 0, 0, 0, 0, 0);
    step(1, 0, 0, 8'd3, 0); expect_out("f1.b3", 1, 0, 0, 8'd3, 0, 0, 0, 0, 0);
    step(1, 0, 1, 8'd4, 0); expect_out("f1.b4", 1, 0, 1, 8'd4, 0, 0, 0, 1, 0);
    // Idle cycle: nothing emitted, data holds.
    step(0, 1, 1, 8'd9, 0); expect_out("idle1", 0, 0, 0, 8'd0, 0, 0, 0, 1, 0);
    check("idle1.data_hold", 32'(o_data), 32'd4);

    // Orphan beat in IDLE.
    step(1, 0, 0, 8'd7, 0); expect_out("orph", 0, 0, 0, 8'd0, 1, 0, 0, 1, 1);
    step(0, 0, 0, 8'd0, 0); expect_out("orph.after", 0, 0, 0, 8'd0, 0, 0, 0, 1, 1);

    // Over-length frame: 6 beats, no eof.
    step(1, 1, 0, 8'd1, 0); expect_out("ovl.b1", 1, 1, 0, 8'd1, 0, 0, 0, 1, 1);
    step(1, 0, 0, 8'd2, 0); expect_out("ovl.b2", 1, 0, 0, 8'd2, 0, 0, 0, 1, 1);
    step(1, 0, 0, 8'd3, 0); expect_out("ovl.b3", 1, 0, 0, 8'd3, 0, 0, 0, 1, 1);
    step(1, 0, 0, 8'd4, 0); expect_out("ovl.b4", 1, 0, 1, 8'd4, 0, 0, 1, 2, 2);
    step(1, 0, 0, 8'd5, 0); expect_out("ovl.b5", 0, 0, 0, 8'd0, 0, 0, 0, 2, 2);
    step(1, 0, 0, 8'd6, 0); expect_out("ovl.b6", 0, 0, 0, 8'd0, 0, 0, 0, 2, 2);

    // Nested sof, starting while still discarding the truncated tail.
    step(1, 1, 0, 8'd1, 0); expect_out("nst.b1", 1, 1, 0, 8'd1, 0, 0, 0, 2, 2);
    step(1, 0, 0, 8'd2, 0); expect_out("nst.b2", 1, 0, 0, 8'd2, 0, 0, 0, 2, 2);
    step(1, 1, 0, 8'd3, 0); expect_out("nst.b3", 1, 1, 0, 8'd3, 0, 1, 0, 2, 3);
    step(1, 0, 1, 8'd4, 0); expect_out("nst.b4", 1, 0, 1, 8'd4, 0, 0, 0, 3, 3);

    // Reset mid-frame: outputs zero during reset, frame abandoned.
    step(1, 1, 0, 8'd1, 0); expect_out("rst.b1", 1, 1, 0, 8'd1, 0, 0, 0, 4, 3);
    step(1, 0, 0, 8'd2, 0); expect_out("rst.b2", 1, 0, 0, 8'd2, 0, 0, 0, 4, 3);
    i_vld   = 1'b0;
    i_rst_n = 1'b0;
    #2;
    expect_all_zero("rst.async");
    @(posedge i_clk);
    #1;
    expect_all_zero("rst.held");
    i_rst_n = 1'b1;
    step(1, 0, 0, 8'd3, 0); expect_out("rst.d3", 0, 0, 0, 8'd0, 1, 0, 0, 0, 1);
    step(1, 0, 1, 8'd4, 0); expect_out("rst.d4", 0, 0, 0, 8'd0, 1, 0, 0, 0, 2);

    // Clear coincident with a single-beat frame: clear wins.
    step(1, 1, 1, 8'd5, 1); expect_out("clr.b", 1, 1, 1, 8'd5, 0, 0, 0, 0, 0);
    step(1, 1, 1, 8'd6, 0); expect_out("clr.next", 1, 1, 1, 8'd6, 0, 0, 0, 1, 0);

    // Truncation exactly at MAX_LEN, then discard ends on eof silently.
    step(1, 1, 0, 8'h11, 0); expect_out("dsc.b1", 1, 1, 0, 8'h11, 0, 0, 0, 1, 0);
    step(1, 0, 0, 8'h12, 0); expect_out("dsc.b2", 1, 0, 0, 8'h12, 0, 0, 0, 1, 0);
    step(1, 0, 0, 8'h13, 0); expect_out("dsc.b3", 1, 0, 0, 8'h13, 0, 0, 0, 1, 0);
    step(1, 0, 0, 8'h14, 0); expect_out("dsc.b4", 1, 0, 1, 8'h14, 0, 0, 1, 2, 1);
    step(1, 0, 1, 8'h15, 0); expect_out("dsc.eof", 0, 0, 0, 8'd0, 0, 0, 0, 2, 1);
    step(1, 0, 0, 8'h16, 0); expect_out("dsc.orph", 0, 0, 0, 8'd0, 1, 0, 0, 2, 2);

    // A frame whose eof lands exactly on beat MAX_LEN is legal.
    step(1, 1, 0, 8'h21, 0); expect_out("max.b1", 1, 1, 0, 8'h21, 0, 0, 0, 2, 2);
    step(1, 0, 0, 8'h22, 0); expect_out("max.b2", 1, 0, 0, 8'h22, 0, 0, 0, 2, 2);
    step(1, 0, 0, 8'h23, 0); expect_out("max.b3", 1, 0, 0, 8'h23, 0, 0, 0, 2, 2);
    step(1, 0, 1, 8'h24, 0); expect_out("max.b4", 1, 0, 1, 8'h24, 0, 0, 0, 3, 2);
    step(0, 0, 0, 8'd0, 0);  expect_out("max.idle", 0, 0, 0, 8'd0, 0, 0, 0, 3, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_avlnst_frame_checker
